// File: rtl/pistorm_pkg.sv
// Shared register map, status bit positions and command record for the Pi-side bridge front end.
package pistorm_pkg;
  localparam int CMD_ADDR_W = 24;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int ST_IN_FLIGHT = 15;
  localparam int ST_FULL      = 14;
  localparam int ST_EMPTY     = 13;
  localparam int ST_OVERFLOW  = 12;
  localparam int ST_RD_VALID  = 11;
  localparam int ST_AUTOINC   = 10;

  localparam int CTL_CLR_OVF = 0;
  localparam int CTL_FLUSH   = 1;
  localparam int CTL_AUTOINC = 2;
  localparam int HI_BYTE     = 8;
  localparam int HI_RW       = 9;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [15:0]           wdata;
    logic                  rw;
    logic                  uds_n;
    logic                  lds_n;
  } pi_cmd_t;

  // Byte accesses pick the lane from addr[0]: even address is the upper byte.
  function automatic pi_cmd_t make_cmd(input logic [CMD_ADDR_W-1:0] addr, input logic [15:0] wdata,
                                       input logic rw, input logic byte_acc);
    pi_cmd_t c;
    c.addr  = addr;
    c.wdata = wdata;
    c.rw    = rw;
    c.uds_n = byte_acc ? addr[0]  : 1'b0;
    c.lds_n = byte_acc ? ~addr[0] : 1'b0;
    return c;
  endfunction
endpackage

// File: rtl/pi_txn_fifo.sv
// Synchronous FIFO of bus commands; a push into a full FIFO is accepted when a pop happens the same cycle.
module pi_txn_fifo
  import pistorm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  pi_cmd_t                    din,
  input  logic                       pop,
  input  logic                       flush,
  output pi_cmd_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  pi_cmd_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pi_txn_queue.sv
// Pi register front end: decodes Pi strobes into queued 68k commands and runs the REQ/ACK/DONE handshake.
// Optional PI_AUTOINC_EN: DATA writes enqueue word writes and step the address by 2.
module pi_txn_queue
  import pistorm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 24
) (
  input  logic              PI_CLK,
  input  logic              PI_RST,
  input  logic [1:0]        PI_A,
  input  logic              PI_WR,
  input  logic              PI_RD,
  input  logic [15:0]       PI_D_IN,
  output logic [15:0]       PI_D_OUT,
  output logic              PI_D_OE,
  output logic              PI_TXN_IN_PROGRESS,
  output logic              BUS_REQ,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [15:0]       BUS_WDATA,
  output logic              BUS_RW,
  output logic              BUS_UDS_n,
  output logic              BUS_LDS_n,
  input  logic              BUS_ACK,
  input  logic              BUS_DONE,
  input  logic [15:0]       BUS_RDATA
);
  logic [2:0]            wr_sync, rd_sync;
  logic                  wr_edge, rd_edge;
  logic                  wr_data, wr_lo, wr_hi, wr_status, rd_data;
  logic [CMD_ADDR_W-1:0] addr_q;
  logic [15:0]           wdata_q, rdata_q;
  logic                  in_flight, in_flight_rw, rd_pend, rd_valid, overflow, autoinc;
  logic                  bus_req, busy;
  logic                  push, push_ok, flush, ack_take, done_take;
  pi_cmd_t               push_cmd, head;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]           status;

  // Two flops to synchronise, the third remembers the previous level for edge detect.
  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      wr_sync <= '0;
      rd_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], PI_WR};
      rd_sync <= {rd_sync[1:0], PI_RD};
    end
  end

  assign wr_edge   = wr_sync[1] && !wr_sync[2];
  assign rd_edge   = rd_sync[1] && !rd_sync[2];
  assign wr_data   = wr_edge && (PI_A == REG_DATA);
  assign wr_lo     = wr_edge && (PI_A == REG_ADDR_LO);
  assign wr_hi     = wr_edge && (PI_A == REG_ADDR_HI);
  assign wr_status = wr_edge && (PI_A == REG_STATUS);
  assign rd_data   = rd_edge && (PI_A == REG_DATA);
  assign flush     = wr_status && PI_D_IN[CTL_FLUSH];
  assign ack_take  = BUS_ACK && bus_req;
  assign done_take = BUS_DONE && in_flight;
  assign push_ok   = push && (!fifo_full || ack_take);

  always_comb begin
    push     = 1'b0;
    push_cmd = make_cmd({PI_D_IN[7:0], addr_q[15:0]}, wdata_q, PI_D_IN[HI_RW], PI_D_IN[HI_BYTE]);
    if (wr_hi) begin
      push = 1'b1;
`ifdef PI_AUTOINC_EN
    end else if (wr_data && autoinc) begin
      push     = 1'b1;
      push_cmd = make_cmd(addr_q, PI_D_IN, 1'b0, 1'b0);
`endif
    end
  end

  pi_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (PI_CLK),
    .rst   (PI_RST),
    .push  (push),
    .din   (push_cmd),
    .pop   (ack_take),
    .flush (flush),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      in_flight    <= 1'b0;
      in_flight_rw <= 1'b0;
      rd_pend      <= 1'b0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      bus_req      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (wr_lo) addr_q[15:0] <= PI_D_IN;
      if (wr_hi) addr_q[23:16] <= PI_D_IN[7:0];
      if (wr_data) begin
        wdata_q <= PI_D_IN;
`ifdef PI_AUTOINC_EN
        if (autoinc) addr_q <= addr_q + 24'd2;
`endif
      end
      if (wr_status && PI_D_IN[CTL_CLR_OVF]) overflow <= 1'b0;
      if (push && !push_ok) overflow <= 1'b1;

      if (ack_take) begin
        in_flight    <= 1'b1;
        in_flight_rw <= head.rw;
      end else if (done_take) begin
        in_flight <= 1'b0;
      end

      if (done_take && in_flight_rw) begin
        rdata_q  <= BUS_RDATA;
        rd_valid <= 1'b1;
        rd_pend  <= 1'b0;
      end
      if (rd_data) rd_valid <= 1'b0;
      // A flushed read never completes, so only a read already handed to the engine keeps the Pi stalled.
      if (flush) rd_pend <= (ack_take && head.rw) || (in_flight && in_flight_rw && !done_take);
      if (push_ok && push_cmd.rw) begin
        rd_pend  <= 1'b1;
        rd_valid <= 1'b0;
      end

      bus_req <= !fifo_empty && !in_flight && !ack_take && !flush;
      busy    <= fifo_full || rd_pend;
    end
  end

`ifdef PI_AUTOINC_EN
  always_ff @(posedge PI_CLK) begin
    if (PI_RST)         autoinc <= 1'b0;
    else if (wr_status) autoinc <= PI_D_IN[CTL_AUTOINC];
  end
`else
  assign autoinc = 1'b0;
`endif

  always_comb begin
    status               = '0;
    status[ST_IN_FLIGHT] = in_flight;
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_OVERFLOW]  = overflow;
    status[ST_RD_VALID]  = rd_valid;
    status[ST_AUTOINC]   = autoinc;
    status[4:0]          = 5'(fifo_count);
  end

  assign PI_D_OE  = PI_RD && ((PI_A == REG_DATA) || (PI_A == REG_STATUS));
  assign PI_D_OUT = !PI_RD                ? 16'h0000 :
                    (PI_A == REG_DATA)    ? rdata_q  :
                    (PI_A == REG_STATUS)  ? status   : 16'h0000;

  assign PI_TXN_IN_PROGRESS = busy;
  assign BUS_REQ   = bus_req;
  assign BUS_ADDR  = bus_req ? ADDR_W'(head.addr) : '0;
  assign BUS_WDATA = bus_req ? head.wdata : 16'h0000;
  assign BUS_RW    = bus_req ? head.rw    : 1'b1;
  assign BUS_UDS_n = bus_req ? head.uds_n : 1'b1;
  assign BUS_LDS_n = bus_req ? head.lds_n : 1'b1;
endmodule

// File: tb/tb_pi_txn_queue.sv
// Bench for pi_txn_queue: directed scenarios plus random Pi/engine traffic against a transaction-level model.
module tb_pi_txn_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pi_a = '0;
  logic        pi_wr = 1'b0, pi_rd = 1'b0;
  logic [15:0] pi_d_in = '0;
  logic [15:0] pi_d_out;
  logic        pi_d_oe, busy;
  logic        bus_req, bus_rw, bus_uds_n, bus_lds_n;
  logic [23:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0, bus_done = 1'b0;
  logic [15:0] bus_rdata = '0;

  always #5 clk = ~clk;

  pi_txn_queue #(.DEPTH(DEPTH), .ADDR_W(24)) dut (
    .PI_CLK(clk), .PI_RST(rst), .PI_A(pi_a), .PI_WR(pi_wr), .PI_RD(pi_rd),
    .PI_D_IN(pi_d_in), .PI_D_OUT(pi_d_out), .PI_D_OE(pi_d_oe), .PI_TXN_IN_PROGRESS(busy),
    .BUS_REQ(bus_req), .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata), .BUS_RW(bus_rw),
    .BUS_UDS_n(bus_uds_n), .BUS_LDS_n(bus_lds_n), .BUS_ACK(bus_ack), .BUS_DONE(bus_done),
    .BUS_RDATA(bus_rdata)
  );

  typedef struct {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } exp_cmd_t;

  exp_cmd_t    mq[$];
  logic [23:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic        m_in_flight, m_fl_rw, m_rd_pend, m_rd_valid, m_ovf, m_autoinc;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void mreset();
    mq.delete();
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_in_flight = 0; m_fl_rw = 0; m_rd_pend = 0; m_rd_valid = 0; m_ovf = 0; m_autoinc = 0;
  endfunction

  function automatic void menq(input logic [23:0] a, input logic [15:0] d, input logic rw, input logic byt);
    exp_cmd_t c;
    c.addr = a; c.wdata = d; c.rw = rw;
    c.uds_n = byt ? a[0] : 1'b0;
    c.lds_n = byt ? !a[0] : 1'b0;
    if (mq.size() < DEPTH) begin
      mq.push_back(c);
      if (rw) begin m_rd_pend = 1; m_rd_valid = 0; end
    end else begin
      m_ovf = 1;
    end
  endfunction

  function automatic void mwrite(input logic [1:0] a, input logic [15:0] d);
    case (a)
      2'd0: begin
        m_wdata = d;
        if (m_autoinc) begin menq(m_addr, d, 1'b0, 1'b0); m_addr = m_addr + 24'd2; end
      end
      2'd1: m_addr[15:0] = d;
      2'd2: begin m_addr[23:16] = d[7:0]; menq(m_addr, m_wdata, d[9], d[8]); end
      default: begin
        if (d[0]) m_ovf = 0;
        if (d[1]) mq.delete();
`ifdef PI_AUTOINC_EN
        m_autoinc = d[2];
`endif
      end
    endcase
  endfunction

  function automatic logic [15:0] mstat();
    logic [15:0] s;
    s = '0;
    s[15] = m_in_flight;
    s[14] = (mq.size() == DEPTH);
    s[13] = (mq.size() == 0);
    s[12] = m_ovf;
    s[11] = m_rd_valid;
    s[10] = m_autoinc;
    s[4:0] = 5'(mq.size());
    return s;
  endfunction

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    pi_a = a; pi_d_in = d; pi_wr = 1'b1;
    repeat (4) @(negedge clk);
    pi_wr = 1'b0;
    mwrite(a, d);
    repeat (4) @(negedge clk);
  endtask

  task automatic pi_read(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk);
    pi_a = a; pi_rd = 1'b1;
    @(negedge clk);
    v = pi_d_out;
    check("oe", pi_d_oe, 1'b1);
    repeat (3) @(negedge clk);
    pi_rd = 1'b0;
    if (a == 2'd0) m_rd_valid = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    logic [15:0] v;
    logic [15:0] e;
    e = mstat();
    pi_read(2'd3, v);
    check(tag, v, e);
  endtask

  task automatic check_busy(input string tag);
    check(tag, busy, (mq.size() == DEPTH) || m_rd_pend);
  endtask

  task automatic send_cmd(input logic [23:0] a, input logic [15:0] d, input logic rw, input logic byt);
    pi_write(2'd1, a[15:0]);
    if (!rw) pi_write(2'd0, d);
    pi_write(2'd2, {6'($urandom_range(0, 63)), rw, byt, a[23:16]});
  endtask

  task automatic check_head(input string tag);
    check({tag, "_addr"}, bus_addr, mq[0].addr);
    check({tag, "_wdata"}, bus_wdata, mq[0].wdata);
    check({tag, "_rw"}, bus_rw, mq[0].rw);
    check({tag, "_uds"}, bus_uds_n, mq[0].uds_n);
    check({tag, "_lds"}, bus_lds_n, mq[0].lds_n);
  endtask

  task automatic ack_only();
    for (int n = 0; n < 50 && !bus_req; n++) @(negedge clk);
    check("req_seen", bus_req, 1'b1);
    if (bus_req && mq.size() > 0) begin
      check_head("head");
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      m_fl_rw = mq[0].rw;
      void'(mq.pop_front());
      m_in_flight = 1;
      check("req_drop", bus_req, 1'b0);
    end
  endtask

  task automatic done_only(input logic [15:0] rd);
    @(negedge clk);
    bus_rdata = rd; bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    if (m_in_flight && m_fl_rw) begin m_rdata = rd; m_rd_valid = 1; m_rd_pend = 0; end
    m_in_flight = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic serve(input logic [15:0] rd);
    ack_only();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (m_in_flight) done_only(rd);
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++) serve(16'($urandom));
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] hi;
    mreset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req", bus_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", pi_d_out, 16'h0000);
    check("rst_addr", bus_addr, 24'h0);
    check("rst_wdata", bus_wdata, 16'h0);
    check("rst_rw", bus_rw, 1'b1);
    check("rst_strb", {bus_uds_n, bus_lds_n}, 2'b11);
    check_status("rst_status");

    // Basic word write.
    send_cmd(24'h001234, 16'hBEEF, 1'b0, 1'b0);
    check("wr_req", bus_req, 1'b1);
    serve(16'h0);
    check_status("wr_status");

    // Byte read on an odd address: lower lane only, Pi stalled until DONE.
    send_cmd(24'h030011, 16'h0, 1'b1, 1'b1);
    check("rd_busy", busy, 1'b1);
    check("rd_uds", bus_uds_n, 1'b1);
    check("rd_lds", bus_lds_n, 1'b0);
    serve(16'h00AB);
    check("rd_unbusy", busy, 1'b0);
    check_status("rd_valid_status");
    pi_read(2'd0, v);
    check("rd_data", v, 16'h00AB);
    check_status("rd_clr_status");

    // Fill with the engine stalled, overflow on the fifth.
    pi_write(2'd1, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      pi_write(2'd2, 16'h0000);
      if (i == 3) begin
        check("full_busy", busy, 1'b1);
        check_status("full_status");
      end
    end
    check_status("ovf_status");
    pi_write(2'd3, 16'h0001);
    check_status("ovf_clr_status");

    // Enqueue landing on the same edge as ACK while full.
    for (int n = 0; n < 50 && !bus_req; n++) @(negedge clk);
    hi = 16'h0042;
    @(negedge clk);
    pi_a = 2'd2; pi_d_in = hi; pi_wr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_head("ackfull");
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    m_fl_rw = mq[0].rw;
    void'(mq.pop_front());
    m_in_flight = 1;
    mwrite(2'd2, hi);
    repeat (3) @(negedge clk);
    pi_wr = 1'b0;
    repeat (4) @(negedge clk);
    check_status("ackfull_status");
    done_only(16'h0);
    drain();
    check_status("drained_status");

`ifdef PI_AUTOINC_EN
    pi_write(2'd3, 16'h0004);
    pi_write(2'd1, 16'hFFFE);
    pi_write(2'd2, 16'h00FF);
    pi_write(2'd0, 16'h1111);
    pi_write(2'd0, 16'h2222);
    check_status("ainc_status");
    drain();
    pi_write(2'd3, 16'h0000);
`else
    pi_write(2'd3, 16'h0004);
    pi_write(2'd0, 16'h5555);
    check_status("noainc_status");
`endif

    // Random Pi and engine traffic.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: send_cmd(24'($urandom), 16'($urandom), 1'b0, 1'($urandom));
        1: send_cmd(24'($urandom), 16'h0, 1'b1, 1'($urandom));
        2: if (mq.size() > 0) serve(16'($urandom));
        3: check_status("rnd_status");
        4: pi_write(2'd3, m_rd_pend ? 16'h0001 : 16'($urandom_range(1, 3)));
        default: begin
          logic [15:0] e;
          e = m_rdata;
          pi_read(2'd0, v);
          check("rnd_rdata", v, e);
        end
      endcase
      check_busy("rnd_busy");
    end
    drain();

    // Reset with a command in flight; the late DONE must be ignored.
    send_cmd(24'h000200, 16'hCAFE, 1'b0, 1'b0);
    ack_only();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mreset();
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    repeat (2) @(negedge clk);
    pi_read(2'd3, v);
    check("rst_fl_status", v, 16'h2000);
    check("rst_fl_req", bus_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
